tdm_demux4: RTL and testbench

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_demux4.sv | 71 +++++++
 tb/tb_tdm_demux4.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// Four-slot serial TDM demultiplexer with a one-deep frame register.
// Flags dropped frames (overrun) and mid-frame start markers (sync_err).
module tdm_demux4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sof,
  input  logic       frame_ready,
  output logic       y0,
  output logic       y1,
  output logic       y2,
  output logic       y3,
  output logic       frame_valid,
  output logic [1:0] slot,
  output logic       overrun,
  output logic       sync_err
);

  logic [2:0] sh;
  logic       done;
  logic       load;

  assign done = din_valid & ~sof & (slot == 2'd3);
  assign load = done & (~frame_valid | frame_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot        <= 2'd0;
      sh          <= 3'b000;
      y0          <= 1'b0;
      y1          <= 1'b0;
      y2          <= 1'b0;
      y3          <= 1'b0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      if (din_valid) begin
        if (sof) begin
          // sof always restarts the frame at slot 0
          sh[0] <= din;
          slot  <= 2'd1;
          if (slot != 2'd0)
            sync_err <= 1'b1;
        end else begin
          unique case (slot)
            2'd0:    sh[0] <= din;
            2'd1:    sh[1] <= din;
            2'd2:    sh[2] <= din;
            default: ;
          endcase
          slot <= slot + 2'd1;
        end
      end

      if (load) begin
        y0          <= sh[0];
        y1          <= sh[1];
        y2          <= sh[2];
        y3          <= din;
        frame_valid <= 1'b1;
      end else if (done) begin
        overrun <= 1'b1;
      end else if (frame_valid & frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed scenarios plus random traffic
// checked against a queue-based frame model.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       sof = 1'b0;
  logic       frame_ready = 1'b0;
  logic       y0, y1, y2, y3;
  logic       frame_valid;
  logic [1:0] slot;
  logic       overrun;
  logic       sync_err;

  int total = 0;
  int bad = 0;

  bit   q[$];
  logic [3:0] m_y;
  logic m_fv, m_ov, m_se;

  wire [3:0] y = {y0, y1, y2, y3};

  tdm_demux4 dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .sof(sof),
    .frame_ready(frame_ready),
    .y0(y0),
    .y1(y1),
    .y2(y2),
    .y3(y3),
    .frame_valid(frame_valid),
    .slot(slot),
    .overrun(overrun),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic dv,
                      input logic s, input logic d,
                      input logic rd);
    logic [3:0] nf;
    bit fin;
    rst = r;
    din_valid = dv;
    sof = s;
    din = d;
    frame_ready = rd;
    @(posedge clk);
    fin = 0;
    nf = 4'b0;
    if (r) begin
      q.delete();
      m_y = 4'b0;
      m_fv = 0;
      m_ov = 0;
      m_se = 0;
    end else begin
      if (dv) begin
        if (s) begin
          if (q.size() != 0) m_se = 1;
          q.delete();
          q.push_back(d);
        end else begin
          q.push_back(d);
        end
        if (q.size() == 4) begin
          nf = {q[0], q[1], q[2], q[3]};
          q.delete();
          fin = 1;
        end
      end
      if (fin) begin
        if (!m_fv || rd) begin
          m_y = nf;
          m_fv = 1;
        end else begin
          m_ov = 1;
        end
      end else if (m_fv && rd) begin
        m_fv = 0;
      end
    end
    #1;
    rst = 1'b0;
    din_valid = 1'b0;
    sof = 1'b0;
    frame_ready = 1'b0;
  endtask

  task automatic send4(input logic [3:0] f,
                       input logic s0, input logic rd_last);
    step(0, 1, s0, f[3], 0);
    step(0, 1, 0, f[2], 0);
    step(0, 1, 0, f[1], 0);
    step(0, 1, 0, f[0], rd_last);
  endtask

  task automatic test_reset();
    step(1, 1, 1, 1, 1);
    total++;
    if ({y, frame_valid, slot, overrun, sync_err} !== 9'b0) begin
      bad++;
      $display("FAIL reset got=%b exp=0",
               {y, frame_valid, slot, overrun, sync_err});
    end
    step(0, 1, 0, 1, 0);
    total++;
    if (slot !== 2'd1) begin
      bad++;
      $display("FAIL reset_first_slot got=%0d exp=1", slot);
    end
  endtask

  task automatic test_basic();
    step(1, 0, 0, 0, 0);
    send4(4'b1011, 1, 0);
    total++;
    if ({y, frame_valid, slot} !== {4'b1011, 1'b1, 2'd0}) begin
      bad++;
      $display("FAIL basic got=%b exp=%b",
               {y, frame_valid, slot}, 7'b1011100);
    end
  endtask

  task automatic test_gapped();
    logic [3:0] f = 4'b0110;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, f[3-i], 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 1, 0);
      total++;
      if (slot !== 2'((i + 1) % 4)) begin
        bad++;
        $display("FAIL gap_slot got=%0d exp=%0d",
                 slot, (i + 1) % 4);
      end
    end
    total++;
    if (y !== 4'b0110 || frame_valid !== 1'b1) begin
      bad++;
      $display("FAIL gapped got=%b/%b exp=0110/1",
               y, frame_valid);
    end
  endtask

  task automatic test_resync();
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 0);
    total++;
    if (sync_err !== 1'b1 || slot !== 2'd1) begin
      bad++;
      $display("FAIL resync got=%b/%0d exp=1/1", sync_err, slot);
    end
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    total++;
    if (y !== 4'b0001 || frame_valid !== 1'b1) begin
      bad++;
      $display("FAIL resync_frame got=%b exp=0001", y);
    end
  endtask

  task automatic test_overrun();
    step(1, 0, 0, 0, 0);
    send4(4'b1111, 1, 0);
    send4(4'b0000, 0, 0);
    total++;
    if (y !== 4'b1111 || overrun !== 1'b1 || slot !== 2'd0) begin
      bad++;
      $display("FAIL overrun got=%b/%b/%0d exp=1111/1/0",
               y, overrun, slot);
    end
    step(0, 0, 0, 0, 1);
    total++;
    if (frame_valid !== 1'b0 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL consume got=%b/%b exp=0/1",
               frame_valid, overrun);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 0, 0);
    send4(4'b0110, 1, 0);
    send4(4'b1001, 0, 1);
    total++;
    if ({y, frame_valid, overrun} !== 6'b100110) begin
      bad++;
      $display("FAIL b2b got=%b exp=100110",
               {y, frame_valid, overrun});
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0, 0);
    send4(4'b1110, 1, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    total++;
    if ({y, frame_valid, slot, overrun, sync_err} !== 9'b0) begin
      bad++;
      $display("FAIL rst_mid got=%b exp=0",
               {y, frame_valid, slot, overrun, sync_err});
    end
    send4(4'b0101, 0, 0);
    total++;
    if ({y, overrun, sync_err} !== 6'b010100) begin
      bad++;
      $display("FAIL rst_mid_frame got=%b exp=010100",
               {y, overrun, sync_err});
    end
  endtask

  task automatic test_random();
    int errs = 0;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 8,
           1'($urandom),
           $urandom_range(0, 99) < 35);
      total++;
      if ({y, frame_valid, slot, overrun, sync_err} !==
          {m_y, m_fv, 2'(q.size()), m_ov, m_se}) begin
        bad++;
        errs++;
        if (errs < 10)
          $display("FAIL random[%0d] got=%b exp=%b", i,
                   {y, frame_valid, slot, overrun, sync_err},
                   {m_y, m_fv, 2'(q.size()), m_ov, m_se});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_resync();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
